// File: rtl/program_store.sv
// program_store: Brainfuck program memory with a self-initialising image.
//   clk_i / rst_i      : clock, asynchronous active-low reset
//   init_sel_i         : image select (0 = built-in test program, 1 = all HALT)
//   reinit_i           : one-cycle request to re-run init from READY
//   busy_o             : init in progress (reads return 0, writes stall)
//   wr_*               : valid/ready host write port
//   ra_* / rb_*        : two independent 1-cycle synchronous read ports
module program_store #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 32,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              init_sel_i,
  input  logic              reinit_i,
  output logic              busy_o,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              ra_en_i,
  input  logic [AW-1:0]     ra_addr_i,
  output logic [DATA_W-1:0] ra_data_o,
  input  logic              rb_en_i,
  input  logic [AW-1:0]     rb_addr_i,
  output logic [DATA_W-1:0] rb_data_o
);

  typedef enum logic {INIT, READY} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     ptr_q;
  logic              sel_q;
  logic              sel_pend_q;   // select not yet sampled since reset
  logic              eff_sel;
  logic              init_we;
  logic              wr_acc;
  logic [DATA_W-1:0] init_word;
  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic [DATA_W-1:0] image(input logic [AW-1:0] a, input logic clr);
    logic [7:0]        b;
    logic [DATA_W-1:0] w;
    b = 8'h00;
    if (!clr) begin
      case (int'(a))
        0:  b = 8'h45;
        1:  b = 8'h01;
        2:  b = 8'h43;
        3:  b = 8'h61;
        4:  b = 8'h21;
        5:  b = 8'h80;
        6:  b = 8'hA0;
        7:  b = 8'hC2;
        8:  b = 8'h80;
        9:  b = 8'h01;
        10: b = 8'hFA;
        default: b = 8'h00;
      endcase
    end
    w      = '0;
    w[7:0] = b;
    return w;
  endfunction

  assign busy_o     = (state_q == INIT);
  assign wr_ready_o = !busy_o;
  assign wr_acc     = wr_valid_i && wr_ready_o;
  assign init_we    = busy_o;
  // First init edge after reset uses the live select; later inits use the
  // value captured on the reinit edge.
  assign eff_sel    = sel_pend_q ? init_sel_i : sel_q;
  assign init_word  = image(ptr_q, eff_sel);

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (ptr_q == '1) state_d = READY;
      READY:   if (reinit_i)    state_d = INIT;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= INIT;
      ptr_q      <= '0;
      sel_q      <= 1'b0;
      sel_pend_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) begin
        ptr_q      <= ptr_q + AW'(1);   // wraps to 0 only as INIT exits
        sel_pend_q <= 1'b0;
        if (sel_pend_q) sel_q <= init_sel_i;
      end else if (reinit_i) begin
        ptr_q <= '0;
        sel_q <= init_sel_i;
      end
    end
  end

  // Init and host writes are exclusive: host writes only land in READY.
  always_ff @(posedge clk_i) begin
    if (init_we)     mem[ptr_q]     <= init_word;
    else if (wr_acc) mem[wr_addr_i] <= wr_data_i;
  end

  // Reads: zero while busy, write-first bypass on address match.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ra_data_o <= '0;
      rb_data_o <= '0;
    end else begin
      if (ra_en_i) begin
        if (busy_o)                             ra_data_o <= '0;
        else if (wr_acc && wr_addr_i == ra_addr_i) ra_data_o <= wr_data_i;
        else                                    ra_data_o <= mem[ra_addr_i];
      end
      if (rb_en_i) begin
        if (busy_o)                             rb_data_o <= '0;
        else if (wr_acc && wr_addr_i == rb_addr_i) rb_data_o <= wr_data_i;
        else                                    rb_data_o <= mem[rb_addr_i];
      end
    end
  end

endmodule

// File: tb/tb_program_store.sv
// Scoreboard bench for program_store: a driver issues one cycle of stimulus,
// computes the expected post-edge outputs from a plain memory model and
// queues them; a monitor pops and compares after each clock edge.
module tb_program_store;
  localparam int DW = 8;
  localparam int DEPTH = 32;
  localparam int AW = 5;

  logic          clk = 0;
  logic          rst = 0;
  logic          init_sel = 0, reinit = 0, wr_valid = 0;
  logic [AW-1:0] wr_addr = 0, ra_addr = 0, rb_addr = 0;
  logic [DW-1:0] wr_data = 0;
  logic          ra_en = 0, rb_en = 0;
  logic          busy, wr_ready;
  logic [DW-1:0] ra_data, rb_data;

  program_store #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .init_sel_i(init_sel), .reinit_i(reinit),
    .busy_o(busy), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .ra_en_i(ra_en), .ra_addr_i(ra_addr), .ra_data_o(ra_data),
    .rb_en_i(rb_en), .rb_addr_i(rb_addr), .rb_data_o(rb_data));

  always #5 clk = ~clk;

  typedef struct {logic [DW-1:0] a; logic [DW-1:0] b; logic busy;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;

  // reference model state
  int            m_left;     // init edges remaining; 0 = ready
  bit            m_pend;
  bit            m_sel;
  logic [DW-1:0] mmem [DEPTH];
  logic [DW-1:0] m_a, m_b;
  bit            last_acc;

  function automatic logic [DW-1:0] img(input int a, input bit clr);
    logic [7:0] prog [11] = '{8'h45, 8'h01, 8'h43, 8'h61, 8'h21, 8'h80,
                              8'hA0, 8'hC2, 8'h80, 8'h01, 8'hFA};
    if (clr || a > 10) return '0;
    return prog[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  exp_t e;
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ra_data", 32'(ra_data), 32'(e.a));
      chk("rb_data", 32'(rb_data), 32'(e.b));
      chk("busy", 32'(busy), 32'(e.busy));
      chk("wr_ready", 32'(wr_ready), 32'(!e.busy));
    end
  end

  task automatic model_reset();
    m_left = DEPTH; m_pend = 1; m_a = '0; m_b = '0;
  endtask

  // One clock of stimulus with the currently driven inputs.
  task automatic step();
    bit   bsy, acc;
    exp_t x;
    bsy = (m_left > 0);
    acc = wr_valid && !bsy;
    if (ra_en) m_a = bsy ? '0 : (acc && wr_addr == ra_addr) ? wr_data : mmem[ra_addr];
    if (rb_en) m_b = bsy ? '0 : (acc && wr_addr == rb_addr) ? wr_data : mmem[rb_addr];
    @(posedge clk);
    last_acc = acc;
    if (acc) mmem[wr_addr] = wr_data;
    if (bsy) begin
      if (m_pend) begin m_sel = init_sel; m_pend = 0; end
      m_left--;
      if (m_left == 0) for (int i = 0; i < DEPTH; i++) mmem[i] = img(i, m_sel);
    end else if (reinit) begin
      m_left = DEPTH; m_sel = init_sel;
    end
    x.a = m_a; x.b = m_b; x.busy = (m_left > 0);
    q.push_back(x);
    @(negedge clk);
  endtask

  task automatic idle();
    reinit = 0; wr_valid = 0; ra_en = 0; rb_en = 0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (busy && n < 100) begin step(); n++; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  int n;
  initial begin
    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
    model_reset();
    #23;
    chk("rst_ra", 32'(ra_data), 0);
    chk("rst_rb", 32'(rb_data), 0);
    chk("rst_busy", 32'(busy), 1);
    @(negedge clk); rst = 1;

    // default image after reset
    wait_ready(n);
    chk("init_edges", n, DEPTH);
    for (int i = 0; i <= 10; i++) begin
      ra_en = 1; ra_addr = AW'(i); rb_en = 1; rb_addr = 5'd31; step();
    end
    idle();

    // write held through init, accepted on first ready edge
    init_sel = 0; reinit = 1; step(); reinit = 0;
    wr_valid = 1; wr_addr = 3; wr_data = 8'h7E; n = 0;
    do begin step(); n++; end while (!last_acc && n < 100);
    chk("held_write_edges", n, DEPTH + 1);
    wr_valid = 0; ra_en = 1; ra_addr = 3; step(); idle();

    // write-first bypass on both ports, then hold
    wr_valid = 1; wr_addr = 5; wr_data = 8'h99;
    ra_en = 1; ra_addr = 5; rb_en = 1; rb_addr = 5; step();
    idle(); step();
    chk("hold_a", 32'(ra_data), 32'h99);

    // clear image; second reinit during busy ignored
    init_sel = 1; reinit = 1; step(); reinit = 0; n = 0;
    while (busy && n < 100) begin
      ra_en = 1; ra_addr = AW'($urandom); rb_en = 1; rb_addr = AW'($urandom);
      reinit = (n == 5); step(); n++;
    end
    chk("clear_busy_cycles", n, DEPTH);
    idle(); ra_en = 1; ra_addr = 0; step(); idle();

    // async reset mid-init at ptr 12
    wr_valid = 1; wr_addr = 7; wr_data = 8'h3C; step(); idle();
    ra_en = 1; ra_addr = 7; rb_en = 1; rb_addr = 7; step(); idle();
    init_sel = 0; reinit = 1; step(); reinit = 0;
    for (int i = 0; i < 12; i++) step();
    #2 rst = 0;
    #1;
    chk("mid_rst_ra", 32'(ra_data), 0);
    chk("mid_rst_rb", 32'(rb_data), 0);
    chk("mid_rst_busy", 32'(busy), 1);
    model_reset();
    @(negedge clk); @(negedge clk); rst = 1;
    wait_ready(n);
    chk("reinit_after_rst_edges", n, DEPTH);
    for (int i = 0; i <= 10; i++) begin
      ra_en = 1; ra_addr = AW'(i); rb_en = 1; rb_addr = AW'(10 - i); step();
    end
    idle();

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_addr  = AW'($urandom); wr_data = DW'($urandom);
      ra_en    = $urandom_range(0, 1); ra_addr = AW'($urandom);
      rb_en    = $urandom_range(0, 1);
      rb_addr  = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
      reinit   = ($urandom_range(0, 39) == 0);
      if (!busy) init_sel = $urandom_range(0, 1);
      step();
    end
    idle(); step(); step();
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/program_store.md
Name: program_store

Overview:
- Parametrised successor to the TinyBF instruction memory.
- Holds the Brainfuck program with two independent synchronous read ports: A for the fetch unit, B for bracket lookahead and debug readback.
- Provides one valid/ready write port for the host loader.
- Self-initialises after reset, or on request, to either the built-in test program or an all-HALT image.

Parameters:
- DATA_W, 8, instruction width in bits; must be ≥ 8.
- DEPTH, 32, number of words; power of 2, ≥ 16.
- AW, $clog2(DEPTH), address width (localparam, not overridable).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-low.
- init_sel_i  in  1  init image select, sampled when init starts: 0 = default test program, 1 = clear to HALT (0).
- reinit_i  in  1  single-cycle request to re-run init without reset.
- busy_o  out  1  high while init is running.
- wr_valid_i  in  1  write request.
- wr_ready_o  out  1  write port can accept (= !busy_o).
- wr_addr_i  in  AW  write address.
- wr_data_i  in  DATA_W  write data.
- ra_en_i  in  1  port A read enable.
- ra_addr_i  in  AW  port A address.
- ra_data_o  out  DATA_W  port A data.
- rb_en_i  in  1  port B read enable.
- rb_addr_i  in  AW  port B address.
- rb_data_o  out  DATA_W  port B data.

Behaviour:
- Reset (async) values:
  - busy_o = 1, ra_data_o = 0, rb_data_o = 0.
  - FSM = INIT, init pointer = 0.
  - init_sel_i is latched at the first rising edge after rst_i deasserts.
- FSM has two states, INIT and READY.
- INIT:
  - Each clock writes mem[ptr] = image(ptr), then ptr increments.
  - After the write to DEPTH-1, go to READY. busy_o drops exactly DEPTH edges after init starts.
- READY:
  - reinit_i = 1 at an edge returns the FSM to INIT with ptr = 0, and latches init_sel_i at that same edge.
  - busy_o rises the following cycle.
  - reinit_i is ignored while in INIT.
- Default image, addresses 0..10: 0x45, 0x01, 0x43, 0x61, 0x21, 0x80, 0xA0, 0xC2, 0x80, 0x01, 0xFA. All other addresses are 0x00.
  - For DATA_W > 8, upper bits are zero.
  - The clear image is 0 everywhere.
- Write handshake:
  - A write is accepted when wr_valid_i && wr_ready_o at the edge, and mem[wr_addr_i] is updated at that edge.
  - While busy_o = 1, wr_valid_i is stalled: nothing is written, and the requester must hold its data.
- Write plus reinit in the same READY cycle: the write is accepted and committed, then init overwrites the whole array.
- Reads:
  - 1-cycle latency per port.
  - With en = 1 at an edge, data_o = mem[addr] on the next cycle.
  - With en = 0, data_o holds its previous value.
  - Both ports may read the same address in the same cycle.
- Write-first bypass: a port reading an address that is being written by an accepted write in the same cycle returns wr_data_i. This applies independently to each port.
- Reads while busy_o = 1: an enabled port returns 0, with no array access. This hides partially initialised contents.
- Address range: addresses are exactly AW bits wide, so there is no out-of-range case. The init pointer does not wrap past DEPTH-1.
- Reset mid-init or mid-read: async reset clears the outputs and restarts init from 0. Array contents are don't-care until the new init completes.

Test Plan:
- Release reset with init_sel_i = 0, then read A at addr 0..10 and B at addr 31 once busy_o falls.
  - busy_o falls after exactly 32 edges.
  - A returns 0x45, 0x01, 0x43, 0x61, 0x21, 0x80, 0xA0, 0xC2, 0x80, 0x01, 0xFA; B returns 0x00.
- Hold wr_valid_i = 1 (addr 3, data 0x7E) during init.
  - wr_ready_o stays 0 until init ends.
  - The write is accepted on the first READY edge; a subsequent A read of addr 3 returns 0x7E.
- In READY, write addr 5 = 0x99 while A and B both read addr 5 in the same cycle.
  - Both ports return 0x99 next cycle.
  - With ra_en_i = 0 on the following cycle, A holds 0x99.
- With init_sel_i = 1, pulse reinit_i.
  - busy_o rises for 32 cycles; reads during that window return 0.
  - Afterwards addr 0 reads 0x00.
  - A second reinit_i pulse during busy_o is ignored, so busy_o stays high for exactly 32 cycles.
- Assert rst_i low at init ptr = 12, then release.
  - Outputs go to 0 immediately and busy_o = 1.
  - Init restarts from 0, and busy_o falls 32 edges after release.
